// File: rtl/vga_matrix_renderer_if.sv
// Matrix-RAM read port plus the buffer-swap handshake shared by the renderer,
// the matrix RAM and the matrix writer.
interface vga_matrix_renderer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    // swap_req is a level held by the writer; swap_ack pulses for one cycle on the
    // vblank rise where buf_sel flips. The writer must drop swap_req after the ack,
    // otherwise another swap is taken at the following vblank rise.
    logic              swap_req;
    logic              swap_ack;
    logic              buf_sel;

    modport master (
        output mem_addr,
        input  mem_data,
        input  swap_req,
        output swap_ack,
        output buf_sel
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        output swap_req,
        input  swap_ack,
        input  buf_sel
    );
endinterface

// File: rtl/vga_matrix_renderer.sv
// Pixel-generation stage: draws a gray-shaded matrix grid from a double-buffered
// RAM and emits RGB, syncs and data enable with a uniform three-register latency.
module vga_matrix_renderer #(
    parameter int          ORIGIN_X   = 80,
    parameter int          ORIGIN_Y   = 0,
    parameter int          CELL_W     = 60,
    parameter int          CELL_H     = 60,
    parameter int          GRID_COLS  = 8,
    parameter int          GRID_ROWS  = 8,
    parameter int          DATA_W     = 8,
    parameter logic [11:0] GRID_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [10:0]                  h_count,
    input  logic [10:0]                  v_count,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         hblank_in,
    input  logic                         vblank_in,
    vga_matrix_renderer_if.master        mem,
    output logic [11:0]                  rgb,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         de_out
);
    localparam int COL_W = $clog2(GRID_COLS);
    localparam int ROW_W = $clog2(GRID_ROWS);

    logic [31:0]      hx;
    logic [31:0]      vy;
    logic             in_x;
    logic             in_y;
    logic             in_grid;
    logic             on_line;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign hx = 32'(h_count);
    assign vy = 32'(v_count);

    // Cell index is the count of cell boundaries already passed, so no divider is needed.
    always_comb begin
        in_x    = (hx >= 32'(ORIGIN_X)) && (hx < 32'(ORIGIN_X + GRID_COLS * CELL_W));
        in_y    = (vy >= 32'(ORIGIN_Y)) && (vy < 32'(ORIGIN_Y + GRID_ROWS * CELL_H));
        in_grid = in_x && in_y;
        col     = '0;
        row     = '0;
        on_line = (hx == 32'(ORIGIN_X + GRID_COLS * CELL_W - 1)) ||
                  (vy == 32'(ORIGIN_Y + GRID_ROWS * CELL_H - 1));
        for (int k = 0; k < GRID_COLS; k++) begin
            if (hx == 32'(ORIGIN_X + k * CELL_W)) on_line = 1'b1;
            if ((k > 0) && (hx >= 32'(ORIGIN_X + k * CELL_W))) col = col + COL_W'(1);
        end
        for (int k = 0; k < GRID_ROWS; k++) begin
            if (vy == 32'(ORIGIN_Y + k * CELL_H)) on_line = 1'b1;
            if ((k > 0) && (vy >= 32'(ORIGIN_Y + k * CELL_H))) row = row + ROW_W'(1);
        end
        on_line = on_line && in_grid;
    end

    logic vblank_s1;
    logic swap_now;
    logic buf_sel_next;

    // Buffer flips only on the first blanking line, so a frame never mixes buffers.
    assign swap_now     = vblank_in && !vblank_s1 && mem.swap_req;
    assign buf_sel_next = mem.buf_sel ^ swap_now;

    logic s1_blank, s1_in_grid, s1_line, s1_hsync, s1_vsync;
    logic s2_blank, s2_in_grid, s2_line, s2_hsync, s2_vsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_s1    <= 1'b1;
            s1_blank     <= 1'b1;
            s1_in_grid   <= 1'b0;
            s1_line      <= 1'b0;
            s1_hsync     <= 1'b1;
            s1_vsync     <= 1'b1;
            mem.mem_addr <= '0;
            mem.buf_sel  <= 1'b0;
            mem.swap_ack <= 1'b0;
        end else begin
            vblank_s1    <= vblank_in;
            s1_blank     <= hblank_in | vblank_in;
            s1_in_grid   <= in_grid;
            s1_line      <= on_line;
            s1_hsync     <= hsync_in;
            s1_vsync     <= vsync_in;
            mem.mem_addr <= {buf_sel_next, row, col};
            mem.buf_sel  <= buf_sel_next;
            mem.swap_ack <= swap_now;
        end
    end

    // Stage 2 waits out the RAM read so the flags line up with mem_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_blank   <= 1'b1;
            s2_in_grid <= 1'b0;
            s2_line    <= 1'b0;
            s2_hsync   <= 1'b1;
            s2_vsync   <= 1'b1;
        end else begin
            s2_blank   <= s1_blank;
            s2_in_grid <= s1_in_grid;
            s2_line    <= s1_line;
            s2_hsync   <= s1_hsync;
            s2_vsync   <= s1_vsync;
        end
    end

    logic [3:0]  gray;
    logic [11:0] pixel;
    logic        unused_mem_bits;

    assign gray            = mem.mem_data[DATA_W-1 -: 4];
    assign unused_mem_bits = ^mem.mem_data;

    always_comb begin
        pixel = '0;
        if (s2_blank)        pixel = 12'h000;
        else if (!s2_in_grid) pixel = BG_COLOR;
        else if (s2_line)    pixel = GRID_COLOR;
        else                 pixel = {gray, gray, gray};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb       <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= pixel;
            de_out    <= !s2_blank;
            hsync_out <= s2_hsync;
            vsync_out <= s2_vsync;
        end
    end
endmodule

// File: tb/tb_vga_matrix_renderer.sv
// Bench for vga_matrix_renderer: arithmetic pixel model with per-cycle compare,
// plus directed literal checks for cells, borders, sync alignment, swaps and reset.
module tb_vga_matrix_renderer;
  localparam int OX = 80;
  localparam int OY = 0;
  localparam int CW = 60;
  localparam int CH = 60;
  localparam int NC = 8;
  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblank_in;
  logic        vblank_in;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;

  vga_matrix_renderer_if #(.ADDR_W(7), .DATA_W(8)) mem_if ();

  vga_matrix_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .h_count   (h_count),
    .v_count   (v_count),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblank_in (hblank_in),
    .vblank_in (vblank_in),
    .mem       (mem_if),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .de_out    (de_out)
  );

  // Matrix RAM with one-cycle read latency
  logic [7:0] ram [128];
  always @(posedge clk) mem_if.mem_data <= ram[mem_if.mem_addr];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_in_grid(input int h, input int v);
    return (h >= OX) && (h < OX + NC * CW) && (v >= OY) && (v < OY + NR * CH);
  endfunction

  function automatic logic model_on_line(input int h, input int v);
    return ((h - OX) % CW == 0) || ((v - OY) % CH == 0) ||
           (h == OX + NC * CW - 1) || (v == OY + NR * CH - 1);
  endfunction

  function automatic logic [6:0] model_addr(input int h, input int v, input logic b);
    int c;
    int r;
    if (!model_in_grid(h, v)) return {b, 6'd0};
    c = (h - OX) / CW;
    r = (v - OY) / CH;
    return {b, 3'(r), 3'(c)};
  endfunction

  function automatic logic [11:0] model_pixel(input int h, input int v, input logic blank, input logic b);
    logic [7:0] d;
    if (blank) return 12'h000;
    if (!model_in_grid(h, v)) return 12'h000;
    if (model_on_line(h, v)) return 12'hFFF;
    d = ram[model_addr(h, v, b)];
    return {d[7:4], d[7:4], d[7:4]};
  endfunction

  typedef struct {
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        in_grid;
    logic        ack;
    logic        bsel;
    logic [6:0]  addr;
  } exp_t;

  exp_t hist[$];
  logic buf_m;
  logic prev_vb;

  // Compare process: pipeline of expectations, checked after every clock edge
  initial begin
    exp_t e;
    exp_t old;
    exp_t blank_e;
    int   h;
    int   v;
    blank_e = '{rgb: 12'h000, de: 1'b0, hs: 1'b1, vs: 1'b1, in_grid: 1'b0,
                ack: 1'b0, bsel: 1'b0, addr: 7'd0};
    buf_m   = 1'b0;
    prev_vb = 1'b1;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        buf_m   = 1'b0;
        prev_vb = 1'b1;
        hist.delete();
        hist.push_back(blank_e);
        hist.push_back(blank_e);
        continue;
      end
      h = int'(h_count);
      v = int'(v_count);
      e.ack = vblank_in && !prev_vb && mem_if.swap_req;
      if (e.ack) buf_m = ~buf_m;
      prev_vb   = vblank_in;
      e.bsel    = buf_m;
      e.in_grid = model_in_grid(h, v);
      e.addr    = model_addr(h, v, buf_m);
      e.rgb     = model_pixel(h, v, hblank_in | vblank_in, buf_m);
      e.de      = !(hblank_in | vblank_in);
      e.hs      = hsync_in;
      e.vs      = vsync_in;
      hist.push_back(e);
      #1;
      if (!reset_n) continue;
      old = hist.pop_front();
      check("rgb", rgb, old.rgb);
      check("de_out", 12'(de_out), 12'(old.de));
      check("hsync_out", 12'(hsync_out), 12'(old.hs));
      check("vsync_out", 12'(vsync_out), 12'(old.vs));
      check("buf_sel", 12'(mem_if.buf_sel), 12'(e.bsel));
      check("swap_ack", 12'(mem_if.swap_ack), 12'(e.ack));
      if (e.in_grid) check("mem_addr", 12'(mem_if.mem_addr), 12'(e.addr));
      else           check("mem_addr_buf", 12'(mem_if.mem_addr[6]), 12'(e.bsel));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_pixel(input int h, input int v, input logic hb, input logic vb);
    h_count   = 11'(h);
    v_count   = 11'(v);
    hblank_in = hb;
    vblank_in = vb;
  endtask

  task automatic frame_edge(input int low_cycles);
    vblank_in = 1'b0;
    repeat (low_cycles) step();
    vblank_in = 1'b1;
  endtask

  initial begin
    int hs_low;
    int hs_de_low;
    int first_low;
    int acks;

    reset_n          = 1'b0;
    hsync_in         = 1'b1;
    vsync_in         = 1'b1;
    mem_if.swap_req  = 1'b0;
    set_pixel(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 128; i++) ram[i] = 8'(i * 37 + 11);
    ram[0] = 8'hA5;

    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (4) step();
    check("post_reset_rgb", rgb, 12'h000);
    check("post_reset_de", 12'(de_out), 12'h000);
    check("post_reset_hsync", 12'(hsync_out), 12'h001);

    // Cell fetch at (81,1)
    set_pixel(81, 1, 1'b0, 1'b0);
    step();
    check("cell0_addr", 12'(mem_if.mem_addr), 12'h000);
    step();
    step();
    check("cell0_rgb", rgb, 12'hAAA);
    check("cell0_de", 12'(de_out), 12'h001);

    // Last cell and right border
    set_pixel(530, 450, 1'b0, 1'b0);
    step();
    check("last_cell_addr", 12'(mem_if.mem_addr), 12'd63);
    set_pixel(559, 450, 1'b0, 1'b0);
    repeat (3) step();
    check("right_border_rgb", rgb, 12'hFFF);

    // Region colours
    set_pixel(10, 100, 1'b0, 1'b0);
    repeat (3) step();
    check("outside_rgb", rgb, 12'h000);
    check("outside_de", 12'(de_out), 12'h001);
    set_pixel(80, 5, 1'b0, 1'b0);
    repeat (3) step();
    check("left_line_rgb", rgb, 12'hFFF);
    set_pixel(200, 100, 1'b1, 1'b0);
    repeat (3) step();
    check("hblank_rgb", rgb, 12'h000);
    check("hblank_de", 12'(de_out), 12'h000);

    // One scan line with a 96-cycle hsync pulse inside horizontal blanking
    hs_low    = 0;
    hs_de_low = 0;
    first_low = -1;
    for (int i = 0; i < 803; i++) begin
      if (i < 800) begin
        set_pixel(i, 100, (i >= 640), 1'b0);
        hsync_in = !((i >= 656) && (i < 752));
      end else begin
        hsync_in = 1'b1;
      end
      step();
      if (!hsync_out) begin
        hs_low++;
        if (!de_out) hs_de_low++;
        if (first_low < 0) first_low = i;
      end
    end
    check("hsync_pulse_len", 12'(hs_low), 12'd96);
    check("hsync_de_coincident", 12'(hs_de_low), 12'd96);
    check("hsync_first_low", 12'(first_low), 12'd658);

    // Swap requested mid-frame waits for the vblank rise
    set_pixel(100, 100, 1'b0, 1'b0);
    mem_if.swap_req = 1'b1;
    repeat (5) step();
    check("no_midframe_swap", 12'(mem_if.buf_sel), 12'h000);
    vblank_in = 1'b1;
    step();
    check("swap1_ack", 12'(mem_if.swap_ack), 12'h001);
    check("swap1_buf", 12'(mem_if.buf_sel), 12'h001);
    check("swap1_addr_msb", 12'(mem_if.mem_addr[6]), 12'h001);
    acks = 1;
    mem_if.swap_req = 1'b0;
    repeat (5) begin
      step();
      if (mem_if.swap_ack) acks++;
    end
    check("swap1_ack_pulses", 12'(acks), 12'd1);

    // Request dropped: next frame keeps the buffer
    frame_edge(3);
    step();
    check("dropped_req_buf", 12'(mem_if.buf_sel), 12'h001);
    check("dropped_req_ack", 12'(mem_if.swap_ack), 12'h000);

    // Request held high: swaps on two consecutive frames
    mem_if.swap_req = 1'b1;
    frame_edge(3);
    step();
    check("held_swap_a", 12'(mem_if.buf_sel), 12'h000);
    frame_edge(3);
    step();
    check("held_swap_b", 12'(mem_if.buf_sel), 12'h001);
    mem_if.swap_req = 1'b0;

    // Request rising with the vblank rise is taken
    frame_edge(3);
    mem_if.swap_req = 1'b1;
    step();
    check("same_edge_swap", 12'(mem_if.buf_sel), 12'h000);
    mem_if.swap_req = 1'b0;

    // Request rising one cycle after the vblank rise waits a frame
    frame_edge(3);
    step();
    mem_if.swap_req = 1'b1;
    step();
    check("late_req_no_swap", 12'(mem_if.buf_sel), 12'h000);
    frame_edge(3);
    step();
    check("late_req_next_frame", 12'(mem_if.buf_sel), 12'h001);
    mem_if.swap_req = 1'b0;

    // Asynchronous reset mid-line with live outputs
    set_pixel(150, 200, 1'b0, 1'b0);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check("areset_rgb", rgb, 12'h000);
    check("areset_de", 12'(de_out), 12'h000);
    check("areset_hsync", 12'(hsync_out), 12'h001);
    check("areset_vsync", 12'(vsync_out), 12'h001);
    check("areset_ack", 12'(mem_if.swap_ack), 12'h000);
    check("areset_buf", 12'(mem_if.buf_sel), 12'h000);
    check("areset_addr", 12'(mem_if.mem_addr), 12'h000);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    set_pixel(0, 0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (4) step();
    check("rereset_rgb", rgb, 12'h000);
    check("rereset_de", 12'(de_out), 12'h000);
    check("rereset_hsync", 12'(hsync_out), 12'h001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
